// File: rtl/rect_draw_sequencer_if.sv
// Shared GPU op type plus the bus bundle between game logic, the draw sequencer and the GPU op FIFO.
package rect_draw_pkg;
  localparam int OP_COORD_W = 16;
  localparam int COLOR_W    = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int SCALE_W    = 4;

  typedef struct packed {
    logic [OP_COORD_W-1:0] x;
    logic [OP_COORD_W-1:0] y;
    logic [OP_COORD_W-1:0] width;
    logic [OP_COORD_W-1:0] height;
    logic [COLOR_W-1:0]    color;
    logic                  mem_en;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [SCALE_W-1:0]    scale;
  } gpu_op_t;
endpackage

// Handshake: an op is accepted by the FIFO on every ce-qualified clock where
// op_wr_en=1; op_wr_en is only raised when op_full was low, and op is stable while it is high.
interface rect_draw_sequencer_if #(
  parameter int SLOTS   = 8,
  parameter int COORD_W = 12
);
  import rect_draw_pkg::*;
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic                  obj_wr_en;
  logic [IDX_W-1:0]      obj_wr_idx;
  logic                  obj_wr_valid;
  logic [COORD_W-1:0]    obj_wr_x;
  logic [COORD_W-1:0]    obj_wr_y;
  logic [COORD_W-1:0]    obj_wr_w;
  logic [COORD_W-1:0]    obj_wr_h;
  logic [COLOR_W-1:0]    obj_wr_color;
  logic                  obj_wr_mem_en;
  logic [MEM_ADDR_W-1:0] obj_wr_mem_addr;
  logic [SCALE_W-1:0]    obj_wr_scale;
  gpu_op_t               op;
  logic                  op_wr_en;
  logic                  op_full;

  modport master (
    output obj_wr_en, obj_wr_idx, obj_wr_valid, obj_wr_x, obj_wr_y, obj_wr_w, obj_wr_h,
    output obj_wr_color, obj_wr_mem_en, obj_wr_mem_addr, obj_wr_scale,
    input  op, op_wr_en,
    output op_full
  );

  modport slave (
    input  obj_wr_en, obj_wr_idx, obj_wr_valid, obj_wr_x, obj_wr_y, obj_wr_w, obj_wr_h,
    input  obj_wr_color, obj_wr_mem_en, obj_wr_mem_addr, obj_wr_scale,
    output op, op_wr_en,
    input  op_full
  );
endinterface

// File: rtl/rect_draw_sequencer.sv
// Per-frame draw sequencer: optional clear op, then one clipped op per valid object slot,
// pushed into the GPU op FIFO; then waits for the buffer swap.
module rect_draw_sequencer
  import rect_draw_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int SLOTS             = 8,
  parameter int COORD_W           = 12,
  parameter bit CLEAR_EN          = 1'b1,
  parameter int CLEAR_COLOR       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        start,
  input  logic                        swap,
  rect_draw_sequencer_if.slave        bus,
  output logic                        busy,
  output logic                        status_wait_gpu,
  output logic                        frame_done,
  output logic [$clog2(SLOTS+2)-1:0]  ops_issued,
  output logic [2:0]                  state_dbg
);
  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int IDXC_W = $clog2(SLOTS + 1);
  localparam int OPS_W  = $clog2(SLOTS + 2);
  localparam int CW     = COORD_W + 1;
  localparam logic signed [CW-1:0] HOR_S = CW'(HOR_ACTIVE_PIXELS);
  localparam logic signed [CW-1:0] VER_S = CW'(VER_ACTIVE_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_FETCH     = 3'd2,
    S_CLIP      = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_SWAP = 3'd5
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0]    x;
    logic [COORD_W-1:0]    y;
    logic [COORD_W-1:0]    w;
    logic [COORD_W-1:0]    h;
    logic [COLOR_W-1:0]    color;
    logic                  mem_en;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [SCALE_W-1:0]    scale;
  } slot_t;

  state_t            state;
  slot_t             slot_mem [SLOTS];
  logic [SLOTS-1:0]  slot_valid;
  slot_t             cur;
  logic              cur_valid;
  logic [IDXC_W-1:0] idx;
  logic              from_slot;

  assign state_dbg = state;

  // Table writes are only safe while the FSM is not walking the table.
  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;
  assign wr_idx = bus.obj_wr_idx;
  assign wr_ok  = ce && bus.obj_wr_en && (int'(wr_idx) < SLOTS) &&
                  (state == S_IDLE || state == S_WAIT_SWAP);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      slot_mem[wr_idx] <= '{x: bus.obj_wr_x, y: bus.obj_wr_y, w: bus.obj_wr_w, h: bus.obj_wr_h,
                            color: bus.obj_wr_color, mem_en: bus.obj_wr_mem_en,
                            mem_addr: bus.obj_wr_mem_addr, scale: bus.obj_wr_scale};
    end
  end

  // Two-axis clip of the fetched slot; sprites must be entirely on screen.
  logic signed [CW-1:0] x_s, y_s, xe, ye, sx, sy, ex, ey;
  logic                 visible, on_screen, take;

  always_comb begin
    x_s       = $signed({cur.x[COORD_W-1], cur.x});
    y_s       = $signed({cur.y[COORD_W-1], cur.y});
    xe        = x_s + $signed({1'b0, cur.w});
    ye        = y_s + $signed({1'b0, cur.h});
    sx        = (x_s < 0) ? '0 : x_s;
    sy        = (y_s < 0) ? '0 : y_s;
    ex        = (xe > HOR_S) ? HOR_S : xe;
    ey        = (ye > VER_S) ? VER_S : ye;
    visible   = cur_valid && (ex > sx) && (ey > sy);
    on_screen = (sx == x_s) && (sy == y_s) && (ex == xe) && (ey == ye);
    take      = visible && (!cur.mem_en || on_screen);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      slot_valid      <= '0;
      bus.op          <= '0;
      bus.op_wr_en    <= 1'b0;
      busy            <= 1'b0;
      status_wait_gpu <= 1'b0;
      frame_done      <= 1'b0;
      ops_issued      <= '0;
      idx             <= '0;
      from_slot       <= 1'b0;
      cur             <= '0;
      cur_valid       <= 1'b0;
    end else if (ce) begin
      frame_done <= 1'b0;
      if (wr_ok) slot_valid[wr_idx] <= bus.obj_wr_valid;

      case (state)
        S_IDLE: begin
          if (start) begin
            ops_issued <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= CLEAR_EN ? S_CLEAR : S_FETCH;
          end
        end
        S_CLEAR: begin
          bus.op          <= '{x: '0, y: '0,
                               width: OP_COORD_W'(HOR_ACTIVE_PIXELS),
                               height: OP_COORD_W'(VER_ACTIVE_PIXELS),
                               color: COLOR_W'(CLEAR_COLOR), mem_en: 1'b0,
                               mem_addr: '0, scale: '0};
          from_slot       <= 1'b0;
          status_wait_gpu <= 1'b1;
          state           <= S_ISSUE;
        end
        S_FETCH: begin
          if (idx == IDXC_W'(SLOTS)) begin
            frame_done <= 1'b1;
            state      <= S_WAIT_SWAP;
          end else begin
            cur       <= slot_mem[idx[IDX_W-1:0]];
            cur_valid <= slot_valid[idx[IDX_W-1:0]];
            state     <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (take) begin
            bus.op          <= '{x: OP_COORD_W'(sx), y: OP_COORD_W'(sy),
                                 width: OP_COORD_W'(ex - sx), height: OP_COORD_W'(ey - sy),
                                 color: cur.color, mem_en: cur.mem_en,
                                 mem_addr: cur.mem_addr, scale: cur.scale};
            from_slot       <= 1'b1;
            status_wait_gpu <= 1'b1;
            state           <= S_ISSUE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_ISSUE: begin
          // Strobe lasts exactly one ce-cycle; op_full is ignored once it is raised.
          if (bus.op_wr_en) begin
            bus.op_wr_en    <= 1'b0;
            status_wait_gpu <= 1'b0;
            if (from_slot) idx <= idx + 1'b1;
            state <= S_FETCH;
          end else if (!bus.op_full) begin
            bus.op_wr_en <= 1'b1;
            ops_issued   <= ops_issued + OPS_W'(1);
          end
        end
        S_WAIT_SWAP: begin
          if (swap) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/rect_draw_sequencer.md
Name: rect_draw_sequencer

Overview:
- Parametrised successor to the hard-coded draw phase of the game CPU.
- Holds a table of SLOTS rectangle/sprite objects written by game logic.
- Per frame: optionally emits a background clear op, then one clipped gpu_op_t per valid slot into the GPU op FIFO, then waits for swap.
- Generalises slot count, screen size, coordinate width and clear mode; adds two-axis signed clipping and culling of partially visible sprites.

Parameters:
HOR_ACTIVE_PIXELS, 640, screen width in pixels
VER_ACTIVE_PIXELS, 480, screen height in pixels
SLOTS, 8, number of object slots (1..32)
COORD_W, 12, width of signed object coordinates
CLEAR_EN, 1, 1 = emit full-screen clear op at frame start
CLEAR_COLOR, 0, colour value of the clear op

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ce  in  1  clock enable; all state advances only when ce=1
start  in  1  begin frame (sampled in IDLE)
swap  in  1  GPU buffer swapped; releases WAIT_SWAP
obj_wr_en  in  1  slot write strobe
obj_wr_idx  in  $clog2(SLOTS)  slot index
obj_wr_valid  in  1  slot enabled
obj_wr_x, obj_wr_y  in  COORD_W each  signed top-left corner
obj_wr_w, obj_wr_h  in  COORD_W each  unsigned size
obj_wr_color, obj_wr_mem_en, obj_wr_mem_addr, obj_wr_scale  in  gpu_op_t field widths  op attributes
op  out  gpu_op_t  op to GPU FIFO
op_wr_en  out  1  FIFO write strobe
op_full  in  1  FIFO full
busy  out  1  not in IDLE
status_wait_gpu  out  1  op pending, blocked or being written
frame_done  out  1  one-cycle pulse on entry to WAIT_SWAP
ops_issued  out  $clog2(SLOTS+2)  ops written this frame

Behaviour:
- Reset: state=IDLE, all slots valid=0, op='0, op_wr_en=0, busy=0, status_wait_gpu=0, frame_done=0, ops_issued=0. Reset mid-frame aborts immediately; a partly issued frame is not resumed.
- Slot writes take effect only when ce=1 and state is IDLE or WAIT_SWAP; otherwise they are dropped. A write with obj_wr_idx>=SLOTS is dropped.
- States: IDLE -> (start) CLEAR or FETCH -> CLIP -> ISSUE -> FETCH ... -> WAIT_SWAP -> (swap) IDLE.
- IDLE: on start, zero ops_issued and slot index. Go to CLEAR if CLEAR_EN=1, else FETCH.
- CLEAR: load op with x=0, y=0, width=HOR, height=VER, color=CLEAR_COLOR, mem_en=0, mem_addr=0, scale=0, then go to ISSUE.
- FETCH: register slot[idx]. If idx==SLOTS, go to WAIT_SWAP.
- CLIP, with all arithmetic signed at COORD_W+1 bits:
  - sx=max(x,0), ex=min(x+w,HOR); sy=max(y,0), ey=min(y+h,VER).
  - Skip the slot (idx++, back to FETCH, no op) if it is invalid, or ex<=sx, or ey<=sy.
  - Skip any mem_en=1 slot that is not fully on screen (sx!=x, ey!=y+h, etc.). Sprites are never clipped.
  - Otherwise load op: x=sx, y=sy, width=ex-sx, height=ey-sy, plus the slot attributes. Go to ISSUE.
- ISSUE: status_wait_gpu=1 from entry. When op_full=0, assert op_wr_en for exactly one ce-cycle, increment ops_issued, then in the next cycle drop op_wr_en and status_wait_gpu. If the op came from a slot, idx++ and go to FETCH; if from CLEAR, go to FETCH.
  - op stays stable while op_wr_en=1.
  - op_full is sampled only before the strobe.
  - The op is never written twice.
- WAIT_SWAP: frame_done pulses one cycle on entry. swap returns to IDLE; start is ignored here. A swap seen in any other state is ignored.
- With ce=0, all outputs hold, including op_wr_en.

Test Plan:
- CLEAR_EN=1, no valid slots, start -> exactly one op (0,0,640,480,color 0), then frame_done; ops_issued=1.
- Slot0 x=-10, y=100, w=40, h=50 (rect) -> op x=0, y=100, width=30, height=50. Slot1 x=620, w=40 -> width=20.
- Slot x=-50, w=40 -> no op. Sprite slot mem_en=1 at x=630, w=34 -> culled. Same sprite at x=20 -> op width=34 with mem_addr passed through.
- Hold op_full=1 for 5 cycles during the first ISSUE -> op_wr_en stays 0, status_wait_gpu=1; exactly one strobe after release, op unchanged.
- Write slot during FETCH/ISSUE -> dropped; the next frame uses the old contents. Write in WAIT_SWAP -> used next frame.
- Assert rst in the middle of the third op's ISSUE -> next cycle op_wr_en=0, busy=0, all slots invalid. A following start with CLEAR_EN=1 emits only the clear op.
